cpu_debug_ctrl: RTL and testbench
=================================

Name: cpu_debug_ctrl

Overview:
- Board-level run/step/breakpoint controller and multiplexed hex display for the CPU on the DE1.
- Replaces the free-running slow clock with a single-cycle CPU clock enable `cpu_en`, generated from `clk` in one of three modes: RUN, STEP or HALT.
- Debounces the pushbuttons, selects one of NUM_CH probe channels, and drives active-low 7-segment digits and status LEDs.
- Sits between the top level, the FSM/datapath enable inputs and the board I/O.

Parameters:
DIV, 6_000_000, clk cycles between cpu_en pulses in RUN (>=2)
DEBOUNCE, 500_000, consecutive stable synchronized cycles required to accept a key level (>=1)
NUM_CH, 16, number of probe channels (2..256)
WIDTH, 16, bits per channel; multiple of 4
DIGITS, 6, number of 7-segment digits; must be >= WIDTH/4+2
START_RUN, 1, mode after reset: 1=RUN, 0=STEP

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high
key_step_n  in  1  raw pushbutton, active-low, asynchronous
key_mode_n  in  1  raw pushbutton, active-low, asynchronous
key_sel_n  in  1  raw pushbutton, active-low, asynchronous
ch_data  in  NUM_CH*WIDTH  probe channels; channel i = bits [i*WIDTH +: WIDTH]
pc  in  16  current CPU program counter
bp_addr  in  16  breakpoint address
bp_en  in  1  breakpoint enable
cpu_en  out  1  single-cycle CPU advance enable
hex_seg  out  DIGITS*7  digit d = bits [d*7 +: 7]; active-low, bit0=a … bit6=g
sel  out  8  selected channel index
mode  out  2  00=STEP, 01=RUN, 10=HALT
bp_hit  out  1  high while in HALT

Behaviour:
- Reset, synchronous, highest priority:
  - mode = RUN if START_RUN else STEP; divider count = 0; sel = 0; cpu_en = 0.
  - Debounced key levels = released; sync flops = 1.
  - Applies in any state, including mid-debounce and mid-divide.
- Key front end, per key:
  - 2-flop synchronizer, then a counter.
  - The debounced level changes only after the synchronized value has differed from it for DEBOUNCE consecutive cycles; any glitch restarts the count.
  - A press event is a one-cycle pulse on the released->pressed transition of the debounced level. Release produces no event.
  - Event latency from the first low raw sample is DEBOUNCE+2 to DEBOUNCE+4 cycles.
- Channel select:
  - A sel event sets sel = sel+1, wrapping from NUM_CH-1 to 0.
  - sel is registered; the display follows one cycle later.
- Display, combinational from registers, no blanking:
  - Digits 0..WIDTH/4-1 show the nibbles of ch_data[sel], least significant first.
  - The next two digits show sel[3:0] and sel[7:4].
  - Any remaining digits show 7'h7F (off).
  - Encoding is the team hex7seg table: 0 -> 7'b1000000, F -> 7'b0001110.
- Divider:
  - Counts 0..DIV-1 while in RUN; tick when count == DIV-1, then wraps to 0.
  - Held at 0 outside RUN; entering RUN starts it from 0.
- State machine, evaluated each cycle; a mode event has priority over a step event in the same cycle, and the step event is dropped.
  - RUN, on tick:
    - If bp_en && pc == bp_addr && !skip: go to HALT, cpu_en stays 0.
    - Otherwise cpu_en = 1 for that cycle and skip clears.
  - RUN, on mode event: go to STEP, clear the divider; a coincident tick is discarded.
  - STEP:
    - Step event: cpu_en = 1 for one cycle; no breakpoint check.
    - Mode event: go to RUN.
  - HALT:
    - Step event: cpu_en = 1 for one cycle, go to STEP.
    - Mode event: go to RUN with skip = 1, so the first tick ignores the breakpoint and advances past it.
- Output timing:
  - cpu_en is registered, exactly one cycle wide, and never asserted on consecutive cycles (DIV>=2).
  - bp_hit = (mode == HALT).
  - pc and bp_addr are sampled only on the tick cycle; changes to bp_en or bp_addr while in HALT do not leave HALT.

Test Plan:
- All scenarios use DIV=4, DEBOUNCE=3, NUM_CH=4, WIDTH=16, DIGITS=6, START_RUN=1.
- Reset, then run free with bp_en=0 -> mode=01; cpu_en pulses on cycles 4, 8, 12… after reset release; sel=0; digits 4,5 = 7'b1000000.
- Bounce key_mode_n low 2 cycles / high 1 / low 10 -> exactly one mode event; mode goes 01->00; no cpu_en afterwards until a step press.
- In STEP, press key_step_n three times (each low 8 cycles) -> exactly three single-cycle cpu_en pulses; mode stays 00.
- RUN, bp_en=1, bp_addr=16'h0005, pc=16'h0005 before a tick -> mode=10, bp_hit=1, no cpu_en on that tick. Then press mode -> mode=01, next tick gives cpu_en=1 despite pc==bp_addr. With pc held at 5, the following tick halts again.
- Channel 2 = 16'hBEEF: press sel twice -> sel=2; digits 0..3 show F,E,E,B; digit 4 shows 2. Press sel twice more -> sel wraps to 0.
- key_mode_n and key_step_n fall in the same cycle while in STEP -> mode=01, no step pulse. Assert reset mid-debounce and mid-divide -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/cpu_debug_ctrl_if.sv
// cpu_debug_ctrl_if: board keys, probe inputs and display/status outputs of the debug controller
interface cpu_debug_ctrl_if #(
    parameter int NUM_CH = 16,
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6
);
    logic                     key_step_n;
    logic                     key_mode_n;
    logic                     key_sel_n;
    logic [NUM_CH*WIDTH-1:0]  ch_data;
    logic [15:0]              pc;
    logic [15:0]              bp_addr;
    logic                     bp_en;
    logic                     cpu_en;
    logic [DIGITS*7-1:0]      hex_seg;
    logic [7:0]               sel;
    logic [1:0]               mode;
    logic                     bp_hit;

    modport master (
        output key_step_n, key_mode_n, key_sel_n, ch_data, pc, bp_addr, bp_en,
        input  cpu_en, hex_seg, sel, mode, bp_hit
    );

    modport slave (
        input  key_step_n, key_mode_n, key_sel_n, ch_data, pc, bp_addr, bp_en,
        output cpu_en, hex_seg, sel, mode, bp_hit
    );
endinterface

// File: rtl/cpu_debug_ctrl.sv
// cpu_debug_ctrl: run/step/breakpoint CPU clock-enable generator with debounced keys and hex probe display
module cpu_debug_ctrl #(
    parameter int DIV       = 6_000_000,
    parameter int DEBOUNCE  = 500_000,
    parameter int NUM_CH    = 16,
    parameter int WIDTH     = 16,
    parameter int DIGITS    = 6,
    parameter int START_RUN = 1
) (
    input logic clk,
    input logic reset,
    cpu_debug_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int VW = $clog2(DIV);

    typedef enum logic [1:0] {STEP = 2'b00, RUN = 2'b01, HALT = 2'b10} mode_t;

    logic [2:0]          raw, sync1, sync2, deb, ev;
    logic [CW-1:0]       cnt [3];
    logic [VW-1:0]       div;
    mode_t               state, state_d;
    logic                skip, skip_d, en_d, cpu_en, tick, bp_match;
    logic [7:0]          sel;
    logic [WIDTH-1:0]    chan;
    logic [WIDTH+7:0]    nib;
    logic [DIGITS*7-1:0] hex;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign raw      = {bus.key_sel_n, bus.key_mode_n, bus.key_step_n};
    assign tick     = state == RUN && div == VW'(DIV - 1);
    assign bp_match = bus.bp_en && bus.pc == bus.bp_addr && !skip;

    // Synchronize and debounce each key; ev pulses once on an accepted press (0=step, 1=mode, 2=sel)
    always_ff @(posedge clk) begin
        sync1 <= reset ? 3'b111 : raw;
        sync2 <= reset ? 3'b111 : sync1;
        for (int k = 0; k < 3; k++) begin
            ev[k] <= !reset && deb[k] && !sync2[k] && cnt[k] == CW'(DEBOUNCE - 1);
            if (reset) begin
                cnt[k] <= '0;
                deb[k] <= 1'b1;
            end else if (sync2[k] == deb[k]) begin
                cnt[k] <= '0;
            end else if (cnt[k] == CW'(DEBOUNCE - 1)) begin
                cnt[k] <= '0;
                deb[k] <= sync2[k];
            end else begin
                cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    // Mode state, skip flag, RUN divider and registered advance enable
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= START_RUN != 0 ? RUN : STEP;
            skip   <= 1'b0;
            div    <= '0;
            cpu_en <= 1'b0;
        end else begin
            state  <= state_d;
            skip   <= skip_d;
            div    <= (state == RUN && state_d == RUN && !tick) ? div + 1'b1 : '0;
            cpu_en <= en_d;
        end
    end

    // Next mode: a mode press beats a step press; the breakpoint is only checked on a RUN tick
    always_comb begin
        state_d = state;
        skip_d  = skip;
        case (state)
            RUN: begin
                if (ev[1]) begin
                    state_d = STEP;
                end else if (tick) begin
                    state_d = bp_match ? HALT : RUN;
                    skip_d  = 1'b0;
                end
            end
            STEP: begin
                if (ev[1]) begin
                    state_d = RUN;
                    skip_d  = 1'b0;
                end
            end
            HALT: begin
                if (ev[1]) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end else if (ev[0]) begin
                    state_d = STEP;
                end
            end
            default: state_d = STEP;
        endcase
    end

    // Advance on an unblocked RUN tick, or on a step press outside RUN, unless a mode press wins
    always_comb en_d = !ev[1] && (state == RUN ? tick && !bp_match : ev[0]);

    // Channel select steps on each sel press and wraps at the last channel
    always_ff @(posedge clk) begin
        if (reset) sel <= 8'd0;
        else if (ev[2]) sel <= sel == 8'(NUM_CH - 1) ? 8'd0 : sel + 8'd1;
    end

    assign chan = bus.ch_data[int'(sel) * WIDTH +: WIDTH];
    assign nib  = {sel, chan};

    // Channel nibbles then the select index, remaining digits dark
    always_comb begin
        hex = '1;
        for (int d = 0; d < WIDTH / 4 + 2; d++) hex[d*7 +: 7] = seg7(nib[d*4 +: 4]);
    end

    assign bus.cpu_en  = cpu_en;
    assign bus.hex_seg = hex;
    assign bus.sel     = sel;
    assign bus.mode    = state;
    assign bus.bp_hit  = state == HALT;
endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// tb_cpu_debug_ctrl: scoreboard bench for the run/step/breakpoint controller
module tb_cpu_debug_ctrl;
    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int NCH = 4;
    localparam int W   = 16;
    localparam int DG  = 6;

    typedef struct { int lo; int hi; } win_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic prev_en = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    win_t exp_q[$];
    win_t w;
    int   r0, c, a, m, h, m2, h2, m3, r1;

    cpu_debug_ctrl_if #(.NUM_CH(NCH), .WIDTH(W), .DIGITS(DG)) bus ();

    cpu_debug_ctrl #(
        .DIV(DIV), .DEBOUNCE(DEB), .NUM_CH(NCH), .WIDTH(W), .DIGITS(DG), .START_RUN(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] dig(input int d);
        return bus.hex_seg[d*7 +: 7];
    endfunction

    task automatic key(input int k, input logic v);
        if (k == 0) bus.key_step_n = v;
        else if (k == 1) bus.key_mode_n = v;
        else bus.key_sel_n = v;
    endtask

    task automatic press(input int k, input int n);
        key(k, 1'b0);
        repeat (n) @(negedge clk);
        key(k, 1'b1);
    endtask

    task automatic step_press();
        exp_q.push_back('{cyc + 6, cyc + 8});
        press(0, 8);
        repeat (10) @(negedge clk);
    endtask

    task automatic sel_press();
        press(2, 8);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_mode(input logic [1:0] md, input int budget, output int at);
        int n = 0;
        while (bus.mode !== md && n < budget) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        if (bus.mode !== md) check("mode_wait", bus.mode, md);
    endtask

    // Every cpu_en pulse must match the oldest expected window and never be two cycles wide
    always @(negedge clk) begin
        if (bus.cpu_en === 1'b1) begin
            check("en_single", prev_en, 1'b0);
            if (exp_q.size() == 0) begin
                check("en_unexpected", cyc, 0);
            end else begin
                w = exp_q.pop_front();
                if (w.lo == w.hi) check("en_cycle", cyc, w.lo);
                else check("en_window", cyc >= w.lo && cyc <= w.hi, 1'b1);
            end
        end
        prev_en <= bus.cpu_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.key_step_n = 1'b1;
        bus.key_mode_n = 1'b1;
        bus.key_sel_n  = 1'b1;
        bus.ch_data    = {16'hA5A5, 16'hBEEF, 16'h1111, 16'hC0DE};
        bus.pc         = 16'h0000;
        bus.bp_addr    = 16'h0000;
        bus.bp_en      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mode", bus.mode, 2'b01);
        check("rst_en", bus.cpu_en, 1'b0);
        check("rst_sel", bus.sel, 8'd0);
        check("rst_bp_hit", bus.bp_hit, 1'b0);
        check("rst_dig0", dig(0), 7'b0000110);
        check("rst_dig3", dig(3), 7'b1000110);
        check("rst_dig4", dig(4), 7'b1000000);
        check("rst_dig5", dig(5), 7'b1000000);

        // Free run: pulses every DIV cycles from reset release
        reset = 1'b0;
        r0 = cyc;
        for (int i = 1; i <= 4; i++) exp_q.push_back('{r0 + 4 * i, r0 + 4 * i});
        while (cyc < r0 + 8) @(negedge clk);
        check("run_mode", bus.mode, 2'b01);
        check("run_sel", bus.sel, 8'd0);

        // Bounced mode key: one event, RUN -> STEP, then silence
        key(1, 1'b0);
        repeat (2) @(negedge clk);
        key(1, 1'b1);
        @(negedge clk);
        key(1, 1'b0);
        c = cyc;
        wait_mode(2'b00, 12, a);
        check("mode_step_lat", a >= c + 6 && a <= c + 8, 1'b1);
        while (cyc < c + 10) @(negedge clk);
        key(1, 1'b1);
        repeat (20) @(negedge clk);
        check("step_mode", bus.mode, 2'b00);
        check("step_idle_q", exp_q.size(), 0);

        // Three step presses, three pulses
        for (int i = 0; i < 3; i++) step_press();
        check("step3_mode", bus.mode, 2'b00);
        check("step3_q", exp_q.size(), 0);

        // Breakpoint at 5 with pc parked on it
        bus.bp_en = 1'b1;
        bus.bp_addr = 16'h0005;
        bus.pc = 16'h0005;
        c = cyc;
        key(1, 1'b0);
        wait_mode(2'b01, 12, m);
        check("mode_run_lat", m >= c + 6 && m <= c + 8, 1'b1);
        while (cyc < c + 8) @(negedge clk);
        key(1, 1'b1);
        wait_mode(2'b10, 12, h);
        check("halt_cycle", h, m + 4);
        check("halt_bp_hit", bus.bp_hit, 1'b1);
        repeat (3) @(negedge clk);
        bus.bp_en = 1'b0;
        bus.bp_addr = 16'h0007;
        repeat (6) @(negedge clk);
        check("halt_hold", bus.mode, 2'b10);
        bus.bp_en = 1'b1;
        bus.bp_addr = 16'h0005;

        // Resume from HALT skips the breakpoint once, then halts again
        c = cyc;
        key(1, 1'b0);
        wait_mode(2'b01, 12, m2);
        exp_q.push_back('{m2 + 4, m2 + 4});
        while (cyc < c + 8) @(negedge clk);
        key(1, 1'b1);
        wait_mode(2'b10, 12, h2);
        check("rehalt_cycle", h2, m2 + 8);
        check("rehalt_q", exp_q.size(), 0);

        // Step out of HALT
        step_press();
        check("halt_step_mode", bus.mode, 2'b00);
        check("halt_step_bp_hit", bus.bp_hit, 1'b0);

        // Channel select and display
        sel_press();
        sel_press();
        check("sel2", bus.sel, 8'd2);
        check("sel2_dig0", dig(0), 7'b0001110);
        check("sel2_dig1", dig(1), 7'b0000110);
        check("sel2_dig2", dig(2), 7'b0000110);
        check("sel2_dig3", dig(3), 7'b0000011);
        check("sel2_dig4", dig(4), 7'b0100100);
        check("sel2_dig5", dig(5), 7'b1000000);
        sel_press();
        check("sel3", bus.sel, 8'd3);
        check("sel3_dig0", dig(0), 7'b0010010);
        check("sel3_dig4", dig(4), 7'b0110000);
        sel_press();
        check("sel_wrap", bus.sel, 8'd0);
        check("sel_wrap_dig0", dig(0), 7'b0000110);
        sel_press();
        check("sel1", bus.sel, 8'd1);
        check("sel_q", exp_q.size(), 0);

        // Simultaneous mode+step in STEP: RUN wins, no step pulse
        bus.bp_en = 1'b0;
        c = cyc;
        key(0, 1'b0);
        key(1, 1'b0);
        wait_mode(2'b01, 12, m3);
        exp_q.push_back('{m3 + 4, m3 + 4});
        check("both_lat", m3 >= c + 6 && m3 <= c + 8, 1'b1);
        while (cyc < c + 8) @(negedge clk);
        key(0, 1'b1);
        key(1, 1'b1);

        // Reset mid-divide and mid-debounce
        while (cyc < m3 + 5) @(negedge clk);
        key(2, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        key(2, 1'b1);
        @(negedge clk);
        check("rst2_mode", bus.mode, 2'b01);
        check("rst2_en", bus.cpu_en, 1'b0);
        check("rst2_sel", bus.sel, 8'd0);
        check("rst2_bp_hit", bus.bp_hit, 1'b0);
        reset = 1'b0;
        r1 = cyc;
        exp_q.push_back('{r1 + 4, r1 + 4});
        exp_q.push_back('{r1 + 8, r1 + 8});
        while (cyc < r1 + 10) @(negedge clk);
        check("post_rst_q", exp_q.size(), 0);
        check("post_rst_sel", bus.sel, 8'd0);
        check("post_rst_mode", bus.mode, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
